// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the inverse key schedule and its round-key consumer.
// The master side loads the round-10 key and accepts keys; the slave side is the schedule.
interface aes_inv_key_schedule_if;
    logic         start;
    logic [127:0] last_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    modport master (
        output start, last_key, key_ready,
        input  busy, key_valid, round_key, round_idx, done
    );

    modport slave (
        input  start, last_key, key_ready,
        output busy, key_valid, round_key, round_idx, done
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: walks from the round-10 key back to the cipher key,
// presenting one round key per valid/ready handshake in decryption order.
module aes_inv_key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_inv_key_schedule_if.slave bus
);
    localparam int NUM_LANES = 4;

    if (NUM_ROUNDS != 10) begin : g_cfg_err
        $error("aes_inv_key_schedule supports only NUM_ROUNDS=10");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic         r_done;

    logic         w_hs;
    logic         w_last;
    logic         w_load;
    logic [7:0]   w_rcon;
    logic [31:0]  w_v0, w_v1, w_v2, w_v3;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [NUM_LANES-1:0][7:0] w_rot;
    logic [NUM_LANES-1:0][7:0] w_sub;
    logic [127:0] w_step;

    // key_valid depends only on state, so there is no key_ready -> key_valid path.
    assign w_hs   = (r_state == S_EMIT) && bus.key_ready;
    assign w_last = (r_idx == 4'd0);
    assign w_load = (r_state == S_IDLE) && bus.start;

    assign w_v0 = r_key[127:96];
    assign w_v1 = r_key[95:64];
    assign w_v2 = r_key[63:32];
    assign w_v3 = r_key[31:0];

    assign w_w3 = w_v3 ^ w_v2;
    assign w_w2 = w_v2 ^ w_v1;
    assign w_w1 = w_v1 ^ w_v0;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign w_sub[l] = SBOX[w_rot[l]];
    end

    always_comb begin
        w_rcon = 8'h00;
        case (r_idx)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Rcon is indexed by the round being undone: key[i-1] derives from key[i] with Rcon[i].
    assign w_w0   = w_v0 ^ w_sub ^ {w_rcon, 24'h000000};
    assign w_step = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)      w_next_state = S_EMIT;
            S_EMIT:  if (w_hs && w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs && w_last;
            if (w_load) begin
                r_key <= bus.last_key;
                r_idx <= 4'(NUM_ROUNDS);
            end else if (w_hs && !w_last) begin
                r_key <= w_step;
                r_idx <= r_idx - 4'd1;
            end
        end
    end

    assign bus.busy      = (r_state == S_EMIT);
    assign bus.key_valid = (r_state == S_EMIT);
    assign bus.round_key = r_key;
    assign bus.round_idx = r_idx;
    assign bus.done      = r_done;
endmodule
